// File: rtl/neg_sub_controller_if.sv
// Bundle between the two requesters, the shared negation unit and the controller.
interface neg_sub_controller_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] neg_in;
  logic [WIDTH-1:0] neg_out;

  // Controller view.
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, neg_out,
    output ack0, ack1, result, ovf, busy, owner, neg_in
  );

  // Requesters plus negation unit view.
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, neg_out,
    input  ack0, ack1, result, ovf, busy, owner, neg_in
  );
endinterface

// File: rtl/neg_sub_controller.sv
// Round-robin sequencer sharing one combinational negator and an adder between two requesters.
module neg_sub_controller #(
  parameter int unsigned WIDTH = 8
) (
  input logic                CLK,
  input logic                RESET_N,
  neg_sub_controller_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNeg  = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StAck  = 2'd3;

  localparam logic [1:0] OpMov = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpSub = 2'b10;
  localparam logic [1:0] OpNeg = 2'b11;

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic             win;
  logic [WIDTH-1:0] exec_res;
  logic             exec_ovf;

  // Result and overflow flag for the latched operation; TMP holds -B (SUB) or -A (NEG).
  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    unique case (op_q)
      OpMov: begin
        exec_res = a_q;
        exec_ovf = 1'b0;
      end
      OpAdd: begin
        exec_res = a_q + b_q;
        exec_ovf = (a_q[Msb] == b_q[Msb]) && (exec_res[Msb] != a_q[Msb]);
      end
      OpSub: begin
        exec_res = a_q + tmp_q;
        exec_ovf = (a_q[Msb] != b_q[Msb]) && (exec_res[Msb] != a_q[Msb]);
      end
      OpNeg: begin
        exec_res = tmp_q;
        exec_ovf = (a_q == MinVal);
      end
      default: begin
        exec_res = '0;
        exec_ovf = 1'b0;
      end
    endcase
  end

  // Next-state: arbitration and operand capture in IDLE, then NEG -> EXEC -> ACK.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tmp_d    = tmp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    owner_d  = owner_q;
    last_d   = last_q;
    win      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // With both pending, the one not served last wins.
          win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          owner_d = win;
          last_d  = win;
          op_d    = win ? bus.op1 : bus.op0;
          a_d     = win ? bus.a1 : bus.a0;
          b_d     = win ? bus.b1 : bus.b0;
          state_d = op_d[1] ? StNeg : StExec;
        end
      end
      StNeg: begin
        tmp_d   = bus.neg_out;
        state_d = StExec;
      end
      StExec: begin
        result_d = exec_res;
        ovf_d    = exec_ovf;
        state_d  = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any operation and makes requester 0 win first.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      op_q     <= OpMov;
      a_q      <= '0;
      b_q      <= '0;
      tmp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tmp_q    <= tmp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  // Outputs decoded from state; negator input is zero outside the NEG state.
  always_comb begin
    bus.neg_in = '0;
    if (state_q == StNeg) begin
      bus.neg_in = (op_q == OpSub) ? b_q : a_q;
    end
    bus.ack0   = (state_q == StAck) && !owner_q;
    bus.ack1   = (state_q == StAck) && owner_q;
    bus.busy   = (state_q != StIdle);
    bus.owner  = owner_q;
    bus.result = result_q;
    bus.ovf    = ovf_q;
  end

endmodule
